// File: rtl/adc_data_unpack_pkg.sv
// -----------------------------------------------------------------------------
// adc_unpack_pkg
// Shared constants and helpers for the ADC receive-side lane unpacker.
//   ST_*          link-state FSM encodings (2 bits)
//   TEST_PATTERN  DAC mux test word as it appears after byte restore
//   LANE_W / NUM_LANES / SAMPLE_W / DATA_W  datapath geometry
//   SWAP_A/SWAP_B lane indices exchanged by the QSTACK5 packing
// -----------------------------------------------------------------------------
package adc_unpack_pkg;

   localparam logic [1:0] ST_DOWN   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;

   localparam int LANE_W    = 32;
   localparam int NUM_LANES = 8;
   localparam int SAMPLE_W  = 16;
   localparam int DATA_W    = LANE_W * NUM_LANES;
   localparam int NUM_BUSES = NUM_LANES / 2;

   localparam int SWAP_A = 4;
   localparam int SWAP_B = 6;

   localparam logic [LANE_W-1:0] TEST_PATTERN = 32'hFF7FFF7F;

   // The JESD core delivers each lane word with its bytes reversed.
   function automatic logic [LANE_W-1:0] byte_restore(input logic [LANE_W-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Source lane for output position 'lane' when the QSTACK5 swap is active.
   function automatic int swap_src(input int lane);
      if (lane == SWAP_A) return SWAP_B;
      if (lane == SWAP_B) return SWAP_A;
      return lane;
   endfunction

endpackage

// File: rtl/adc_data_unpack_lane_restore.sv
// -----------------------------------------------------------------------------
// adc_lane_restore
// Two-stage lane front end: S1 restores byte order inside every 32-bit lane
// word, S2 undoes the QSTACK5 lane 4/6 exchange. Valid travels with the data.
//   clk_i             user clock
//   rst_ni            asynchronous active-low reset
//   qstack_version_i  0 = QSTACK5 (swap lanes 4/6), 1 = QSTACK4 (identity)
//   valid_i / data_i  incoming beat (256 b, 8 lanes)
//   valid_o / data_o  restored beat, 2 cycles after input
// -----------------------------------------------------------------------------
module adc_lane_restore
   import adc_unpack_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              qstack_version_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic              s1_valid_q;
   logic              s2_valid_q;
   logic [LANE_W-1:0] s1_lane [NUM_LANES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= valid_i;
         s2_valid_q <= s1_valid_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         localparam int SRC = swap_src(gi);

         logic [LANE_W-1:0] s1_q;
         logic [LANE_W-1:0] s1_d;
         logic [LANE_W-1:0] s2_q;
         logic [LANE_W-1:0] s2_d;

         assign s1_d        = byte_restore(data_i[gi*LANE_W +: LANE_W]);
         assign s1_lane[gi] = s1_q;
         // qstack_version is sampled live here, so a change hits the very
         // next beat leaving S1; nothing is flushed.
         assign s2_d = qstack_version_i ? s1_lane[gi] : s1_lane[SRC];

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               s1_q <= '0;
               s2_q <= '0;
            end else begin
               s1_q <= s1_d;
               s2_q <= s2_d;
            end
         end

         assign data_o[gi*LANE_W +: LANE_W] = s2_q;
      end
   endgenerate

   assign valid_o = s2_valid_q;

endmodule

// File: rtl/adc_data_unpack.sv
// -----------------------------------------------------------------------------
// adc_data_unpack
// Receive-side counterpart of the DAC lane packer: restores lane byte order,
// undoes the QSTACK5 lane swap, splits the 256-bit beat into four 4-sample
// buses, gates output with a DOWN/SETTLE/RUN link FSM and counts stream gaps.
// Optional feature: define ADC_PATTERN_CHK_EN to add the test-pattern checker
// driving pat_err_cnt; otherwise pat_err_cnt is tied to zero.
// Ports:
//   clk_user_bufg   only clock
//   rst_n           asynchronous active-low reset
//   qstack_version  0 = QSTACK5 (lanes 4/6 swapped), 1 = QSTACK4
//   rx_sync         JESD link synced
//   rx_tvalid/rx_tdata  incoming beat, lane n at [32n+31:32n]
//   cfg_clr         pulse: clear gap_cnt and pat_err_cnt
//   adc0_i/adc0_q/adc1_i/adc1_q  sample buses, ch00 at [15:0] .. ch03 at [63:48]
//   out_valid       sample buses updated this cycle
//   link_up         FSM in RUN
//   link_drop       one-cycle pulse when sync is lost in SETTLE or RUN
//   gap_cnt         saturating count of RUN cycles without a beat
//   pat_err_cnt     saturating count of bad test-pattern beats
// -----------------------------------------------------------------------------
module adc_data_unpack
   import adc_unpack_pkg::*;
#(
   parameter int SETTLE_BEATS = 16,
   parameter int GAP_CNT_W    = 16
)(
   input  logic                 clk_user_bufg,
   input  logic                 rst_n,
   input  logic                 qstack_version,
   input  logic                 rx_sync,
   input  logic                 rx_tvalid,
   input  logic [DATA_W-1:0]    rx_tdata,
   input  logic                 cfg_clr,
   output logic [63:0]          adc0_i,
   output logic [63:0]          adc0_q,
   output logic [63:0]          adc1_i,
   output logic [63:0]          adc1_q,
   output logic                 out_valid,
   output logic                 link_up,
   output logic                 link_drop,
   output logic [GAP_CNT_W-1:0] gap_cnt,
   output logic [15:0]          pat_err_cnt
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_BEATS - 1);

   logic                 rx_sync_d1_q;
   logic                 rx_sync_d2_q;
   logic [1:0]           state_q;
   logic [1:0]           state_d;
   logic                 in_run;
   logic                 in_link;
   logic [7:0]           settle_cnt_q;
   logic                 link_drop_q;
   logic [GAP_CNT_W-1:0] gap_q;
   logic                 s2_valid;
   logic [DATA_W-1:0]    s2_data;
   logic                 out_valid_q;
   logic                 out_valid_d;
   logic [63:0]          bus [NUM_BUSES];

   // ---------------- sync pipeline ----------------
   always_ff @(posedge clk_user_bufg or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync_d1_q <= 1'b0;
         rx_sync_d2_q <= 1'b0;
      end else begin
         rx_sync_d1_q <= rx_sync;
         rx_sync_d2_q <= rx_sync_d1_q;
      end
   end

   // ---------------- link FSM ----------------
   always_ff @(posedge clk_user_bufg or negedge rst_n) begin
      if (!rst_n) state_q <= ST_DOWN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_DOWN:   if (rx_sync_d1_q) state_d = ST_SETTLE;
         ST_SETTLE: begin
            if (!rx_sync_d1_q)
               state_d = ST_DOWN;
            else if (rx_tvalid && (settle_cnt_q == SETTLE_LAST))
               state_d = ST_RUN;
         end
         ST_RUN:    if (!rx_sync_d1_q) state_d = ST_DOWN;
         default:   state_d = ST_DOWN;
      endcase
   end

   always_comb begin
      in_run  = (state_q == ST_RUN);
      in_link = (state_q == ST_SETTLE) || (state_q == ST_RUN);
   end

   // Beat counter only runs in SETTLE, so every fresh SETTLE starts at zero.
   always_ff @(posedge clk_user_bufg or negedge rst_n) begin
      if (!rst_n)                   settle_cnt_q <= '0;
      else if (state_q != ST_SETTLE) settle_cnt_q <= '0;
      else if (rx_tvalid)           settle_cnt_q <= settle_cnt_q + 8'd1;
   end

   always_ff @(posedge clk_user_bufg or negedge rst_n) begin
      if (!rst_n) link_drop_q <= 1'b0;
      else        link_drop_q <= rx_sync_d2_q & ~rx_sync_d1_q & in_link;
   end

   // ---------------- S1 + S2 ----------------
   // Valid is tagged with RUN at S1 entry; beats accepted during SETTLE
   // therefore never produce out_valid.
   adc_lane_restore u_restore (
      .clk_i            (clk_user_bufg),
      .rst_ni           (rst_n),
      .qstack_version_i (qstack_version),
      .valid_i          (rx_tvalid & in_run),
      .data_i           (rx_tdata),
      .valid_o          (s2_valid),
      .data_o           (s2_data)
   );

   // ---------------- S3 unpack ----------------
   // Re-qualifying with RUN here lets beats still in flight at a link drop
   // drain silently.
   assign out_valid_d = s2_valid & in_run;

   always_ff @(posedge clk_user_bufg or negedge rst_n) begin
      if (!rst_n) out_valid_q <= 1'b0;
      else        out_valid_q <= out_valid_d;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BUSES; gi++) begin : g_bus
         logic [LANE_W-1:0] w_even;
         logic [LANE_W-1:0] w_odd;
         logic [63:0]       bus_q;

         assign w_even = s2_data[(2*gi)*LANE_W   +: LANE_W];
         assign w_odd  = s2_data[(2*gi+1)*LANE_W +: LANE_W];

         // Even word carries ch00 (upper) / ch02 (lower), odd word ch01 / ch03.
         always_ff @(posedge clk_user_bufg or negedge rst_n) begin
            if (!rst_n)
               bus_q <= '0;
            else if (out_valid_d)
               bus_q <= {w_odd[SAMPLE_W-1:0],       w_even[SAMPLE_W-1:0],
                         w_odd[LANE_W-1:SAMPLE_W],  w_even[LANE_W-1:SAMPLE_W]};
         end

         assign bus[gi] = bus_q;
      end
   endgenerate

   // ---------------- gap counter ----------------
   always_ff @(posedge clk_user_bufg or negedge rst_n) begin
      if (!rst_n)
         gap_q <= '0;
      else if (cfg_clr)
         gap_q <= '0;
      else if (in_run && !rx_tvalid && (gap_q != '1))
         gap_q <= gap_q + GAP_CNT_W'(1);
   end

   // ---------------- optional pattern checker ----------------
`ifdef ADC_PATTERN_CHK_EN
   logic        pat_bad;
   logic [15:0] pat_err_q;

   always_comb begin
      pat_bad = 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (s2_data[l*LANE_W +: LANE_W] != TEST_PATTERN) pat_bad = 1'b1;
      end
   end

   always_ff @(posedge clk_user_bufg or negedge rst_n) begin
      if (!rst_n)
         pat_err_q <= '0;
      else if (cfg_clr)
         pat_err_q <= '0;
      else if (s2_valid && in_run && pat_bad && (pat_err_q != 16'hFFFF))
         pat_err_q <= pat_err_q + 16'd1;
   end

   assign pat_err_cnt = pat_err_q;
`else
   assign pat_err_cnt = 16'h0000;
`endif

   assign adc0_i    = bus[0];
   assign adc0_q    = bus[1];
   assign adc1_i    = bus[2];
   assign adc1_q    = bus[3];
   assign out_valid = out_valid_q;
   assign link_up   = in_run;
   assign link_drop = link_drop_q;
   assign gap_cnt   = gap_q;

endmodule
